// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that serialises single-byte requests from N_REQ agents onto one i2c_master.
// Each grant gets NACK retries, a bus-free gap afterwards and a watchdog on the master's completion.
module i2c_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MAX_RETRY   = 2,
    parameter int GAP_CYC     = 500,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_err,
    output logic               rsp_timeout,
    output logic               arb_busy,
    output logic               m_start,
    output logic               m_rw_bit,
    output logic [6:0]         m_slave_addr,
    output logic [7:0]         m_tx_data,
    input  logic [7:0]         m_rx_data,
    input  logic               m_busy,
    input  logic               m_done,
    input  logic               m_ack_error
);

    localparam int IW = $clog2(N_REQ);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    // Handshakes: a requester holds req (level) until its own one-cycle rsp_valid; towards the
    // master, m_start is a one-cycle pulse issued only while m_busy is low, answered by one m_done pulse.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RETRY_GAP,
        S_RESP,
        S_POST_GAP
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   last, last_n;
    logic [2:0]      retry_cnt, retry_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic [WW-1:0]   wd_cnt, wd_n;
    logic [N_REQ-1:0] gnt_n, rsp_valid_n;
    logic [7:0]      rsp_rdata_n, m_tx_n;
    logic [6:0]      m_addr_n;
    logic            rsp_err_n, rsp_timeout_n, m_start_n, m_rw_n, arb_busy_n;

    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [IW:0]     cand;

    // Search upward from last+1 with wrap, so the previous owner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last;
        cand       = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (IW+1)'(int'(last) + off);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!pick_found && req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_n       = state;
        last_n        = last;
        retry_n       = retry_cnt;
        gap_n         = gap_cnt;
        wd_n          = wd_cnt;
        gnt_n         = gnt;
        rsp_valid_n   = '0;
        rsp_rdata_n   = rsp_rdata;
        rsp_err_n     = 1'b0;
        rsp_timeout_n = 1'b0;
        m_start_n     = 1'b0;
        m_rw_n        = m_rw_bit;
        m_addr_n      = m_slave_addr;
        m_tx_n        = m_tx_data;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_n    = ONE_HOT0 << pick_idx;
                    last_n   = pick_idx;
                    retry_n  = '0;
                    m_rw_n   = req_rw[pick_idx];
                    m_addr_n = req_addr[int'(pick_idx)*7 +: 7];
                    m_tx_n   = req_wdata[int'(pick_idx)*8 +: 8];
                    state_n  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!m_busy) begin
                    m_start_n = 1'b1;
                    wd_n      = '0;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_n = wd_cnt + WW'(1);
                // m_done has priority over a watchdog expiry in the same cycle.
                if (m_done) begin
                    if (!m_ack_error) begin
                        rsp_rdata_n = m_rx_data;
                        rsp_valid_n = gnt;
                        state_n     = S_RESP;
                    end else if (retry_cnt < 3'(MAX_RETRY)) begin
                        retry_n = retry_cnt + 3'd1;
                        gap_n   = '0;
                        state_n = S_RETRY_GAP;
                    end else begin
                        rsp_valid_n = gnt;
                        rsp_err_n   = 1'b1;
                        state_n     = S_RESP;
                    end
                end else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_n   = gnt;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    state_n       = S_RESP;
                end
            end
            S_RETRY_GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    state_n = S_ISSUE;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            S_RESP: begin
                gap_n   = '0;
                state_n = S_POST_GAP;
            end
            S_POST_GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    gnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
        arb_busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            last         <= IW'(N_REQ - 1);
            retry_cnt    <= '0;
            gap_cnt      <= '0;
            wd_cnt       <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
            arb_busy     <= 1'b0;
            m_start      <= 1'b0;
            m_rw_bit     <= 1'b0;
            m_slave_addr <= '0;
            m_tx_data    <= '0;
        end else begin
            state        <= state_n;
            last         <= last_n;
            retry_cnt    <= retry_n;
            gap_cnt      <= gap_n;
            wd_cnt       <= wd_n;
            gnt          <= gnt_n;
            rsp_valid    <= rsp_valid_n;
            rsp_rdata    <= rsp_rdata_n;
            rsp_err      <= rsp_err_n;
            rsp_timeout  <= rsp_timeout_n;
            arb_busy     <= arb_busy_n;
            m_start      <= m_start_n;
            m_rw_bit     <= m_rw_n;
            m_slave_addr <= m_addr_n;
            m_tx_data    <= m_tx_n;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: behavioural i2c_master model, response scoreboard,
// and one task per scenario.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;

    localparam int N   = 4;
    localparam int GAP = 8;
    localparam int TMO = 64;
    localparam int EW  = 15;  // {owner[3:0], err, timeout, check_rdata, rdata[7:0]}

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_rw = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_err, rsp_timeout, arb_busy, m_start, m_rw_bit;
    logic [6:0]     m_slave_addr;
    logic [7:0]     m_tx_data;
    logic [7:0]     m_rx_data = '0;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic           m_ack_error = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // master model controls and log
    int         mdl_lat = 4;
    int         mdl_nacks = 0;    // 100 means NACK forever
    bit         mdl_silent = 1'b0;
    logic [7:0] mdl_rdata = '0;
    int         mdl_cnt = 0;
    int         start_cnt = 0, start_cyc = 0, done_cyc = 0, min_sp = 0;
    logic [6:0] st_addr = '0;
    logic [7:0] st_data = '0;
    logic       st_rw = 1'b0;

    // scoreboard / monitor state
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e, mon_got;
    int            rsp_cnt = 0, rsp_cyc = 0, gnt_cnt = 0, gnt_cyc = 0;
    logic [N-1:0]  gnt_val = '0, gnt_prev = '0, rsp_prev = '0;

    i2c_bus_arbiter #(
        .N_REQ(N), .MAX_RETRY(2), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .arb_busy(arb_busy), .m_start(m_start),
        .m_rw_bit(m_rw_bit), .m_slave_addr(m_slave_addr), .m_tx_data(m_tx_data),
        .m_rx_data(m_rx_data), .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error)
    );

    // clock and reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // i2c_master model, driven on the falling edge so the DUT samples stable values
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ack_error = 1'b0;
            mdl_cnt = 0;
        end else begin
            m_done = 1'b0;
            m_ack_error = 1'b0;
            if (m_start) begin
                n_cmp++;
                if (m_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_while_busy: m_start seen with m_busy=%b, required m_busy=0", m_busy);
                end
                if (cyc - done_cyc < min_sp) min_sp = cyc - done_cyc;
                start_cnt++;
                start_cyc = cyc;
                st_addr = m_slave_addr;
                st_data = m_tx_data;
                st_rw = m_rw_bit;
                m_busy = 1'b1;
                mdl_cnt = mdl_lat;
            end else if (m_busy) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    m_busy = 1'b0;
                    if (!mdl_silent) begin
                        m_done = 1'b1;
                        m_ack_error = (mdl_nacks > 0);
                        if (mdl_nacks > 0 && mdl_nacks < 100) mdl_nacks--;
                        m_rx_data = mdl_rdata;
                        done_cyc = cyc;
                    end
                end
            end
        end
    end

    // response scoreboard and grant monitor
    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            n_cmp++;
            if (rsp_prev !== '0) begin
                n_fail++;
                $display("FAIL rsp_width: rsp_valid=%b high a second cycle, required a one-cycle pulse", rsp_valid);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got valid=%b err=%b tmo=%b, required no response",
                         rsp_valid, rsp_err, rsp_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                mon_got = {rsp_valid, rsp_err, rsp_timeout, mon_e[8], (mon_e[8] ? rsp_rdata : mon_e[7:0])};
                if (mon_got !== mon_e) begin
                    n_fail++;
                    $display("FAIL rsp_scoreboard: got %h required %h ({owner,err,tmo,chk,rdata})", mon_got, mon_e);
                end
            end
            rsp_cnt++;
            rsp_cyc = cyc;
        end
        rsp_prev = rsp_valid;
        if (gnt_prev === '0 && gnt !== '0) begin
            gnt_cnt++;
            gnt_cyc = cyc;
            gnt_val = gnt;
        end
        gnt_prev = gnt;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[i] = rw;
        req_addr[7*i +: 7] = a;
        req_wdata[8*i +: 8] = d;
        req[i] = 1'b1;
    endtask

    task automatic wait_rsp(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            tick();
            if (rsp_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_gnt(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            tick();
            if (gnt_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_start(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            tick();
            if (start_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            tick();
            if (arb_busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, arb_busy, m_start, m_rw_bit,
             m_slave_addr, m_tx_data} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: outputs %h, required all 0",
                     {gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, arb_busy, m_start,
                      m_rw_bit, m_slave_addr, m_tx_data});
        end
        rst_n = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (arb_busy !== 1'b0 || gnt !== '0) begin
            n_fail++;
            $display("FAIL idle_no_req: arb_busy=%b gnt=%b, required 0/0", arb_busy, gnt);
        end
    endtask

    task automatic test_single_write();
        bit ok;
        int s0, r0, g0, req_c;
        wait_idle(ok);
        s0 = start_cnt; r0 = rsp_cnt; g0 = gnt_cnt;
        mdl_lat = 4; mdl_nacks = 0; mdl_silent = 1'b0; mdl_rdata = 8'h00;
        set_req(1, 1'b0, 7'h55, 8'hFF);
        req_c = cyc;
        exp_q.push_back({4'b0010, 1'b0, 1'b0, 1'b0, 8'h00});
        wait_gnt(g0 + 1, ok);
        n_cmp++;
        if (!ok || gnt_val !== 4'b0010) begin
            n_fail++;
            $display("FAIL write_gnt: gnt=%b ok=%0d, required 0010", gnt_val, ok);
        end
        wait_rsp(r0 + 1, ok);
        req[1] = 1'b0;
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL write_rsp_wait: no rsp_valid within bound, required one"); end
        n_cmp++;
        if (start_cnt - s0 !== 1) begin
            n_fail++; $display("FAIL write_starts: %0d m_start pulses, required 1", start_cnt - s0);
        end
        n_cmp++;
        if (start_cyc !== req_c + 2) begin
            n_fail++; $display("FAIL req_to_start: latency %0d, required 2", start_cyc - req_c);
        end
        n_cmp++;
        if ({st_rw, st_addr, st_data} !== {1'b0, 7'h55, 8'hFF}) begin
            n_fail++; $display("FAIL write_fields: rw/addr/data %b/%h/%h, required 0/55/ff", st_rw, st_addr, st_data);
        end
        n_cmp++;
        if (rsp_cyc !== done_cyc + 1) begin
            n_fail++; $display("FAIL done_to_rsp: %0d cycles, required 1", rsp_cyc - done_cyc);
        end
    endtask

    task automatic test_read();
        bit ok;
        int r0;
        wait_idle(ok);
        r0 = rsp_cnt;
        mdl_rdata = 8'hA5;
        set_req(2, 1'b1, 7'h57, 8'h00);
        exp_q.push_back({4'b0100, 1'b0, 1'b0, 1'b1, 8'hA5});
        wait_rsp(r0 + 1, ok);
        req[2] = 1'b0;
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL read_rsp_wait: no rsp_valid within bound, required one"); end
        n_cmp++;
        if (st_rw !== 1'b1 || st_addr !== 7'h57) begin
            n_fail++; $display("FAIL read_fields: rw/addr %b/%h, required 1/57", st_rw, st_addr);
        end
        repeat (3) tick();
        n_cmp++;
        if (rsp_rdata !== 8'hA5) begin
            n_fail++; $display("FAIL read_hold: rsp_rdata %h, required a5", rsp_rdata);
        end
        mdl_rdata = 8'h00;
    endtask

    task automatic test_round_robin();
        bit ok;
        int g0, r0, prev_rsp;
        logic [N-1:0] exp_g;
        #2 rst_n = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        g0 = gnt_cnt; r0 = rsp_cnt; prev_rsp = 0;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
        end
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % N);
            exp_q.push_back({exp_g, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % N);
            wait_gnt(g0 + g + 1, ok);
            n_cmp++;
            if (!ok || gnt_val !== exp_g) begin
                n_fail++; $display("FAIL rr_order[%0d]: gnt=%b ok=%0d, required %b", g, gnt_val, ok, exp_g);
            end
            if (g > 0) begin
                n_cmp++;
                if (gnt_cyc - prev_rsp < GAP + 1) begin
                    n_fail++; $display("FAIL rr_spacing[%0d]: %0d cycles, required >= %0d", g, gnt_cyc - prev_rsp, GAP + 1);
                end
            end
            wait_rsp(r0 + g + 1, ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL rr_rsp_wait[%0d]: no rsp_valid within bound", g); end
            prev_rsp = rsp_cyc;
        end
        req = '0;
    endtask

    task automatic test_nack(input bit exhaust);
        bit ok;
        int s0, r0;
        wait_idle(ok);
        s0 = start_cnt; r0 = rsp_cnt;
        min_sp = 1000000;
        mdl_nacks = exhaust ? 100 : 2;
        set_req(0, 1'b0, 7'h21, 8'h5A);
        exp_q.push_back({4'b0001, exhaust, 1'b0, 1'b0, 8'h00});
        wait_rsp(r0 + 1, ok);
        req[0] = 1'b0;
        mdl_nacks = 0;
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL nack_rsp_wait[%0d]: no rsp_valid within bound", exhaust); end
        n_cmp++;
        if (start_cnt - s0 !== 3) begin
            n_fail++; $display("FAIL nack_starts[%0d]: %0d m_start pulses, required 3", exhaust, start_cnt - s0);
        end
        n_cmp++;
        if (min_sp < GAP + 2) begin
            n_fail++; $display("FAIL retry_spacing[%0d]: %0d cycles, required >= %0d", exhaust, min_sp, GAP + 2);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int s0, r0;
        wait_idle(ok);
        r0 = rsp_cnt;
        mdl_silent = 1'b1;
        set_req(3, 1'b0, 7'h0C, 8'h77);
        exp_q.push_back({4'b1000, 1'b1, 1'b1, 1'b0, 8'h00});
        wait_rsp(r0 + 1, ok);
        req[3] = 1'b0;
        mdl_silent = 1'b0;
        n_cmp++;
        if (!ok || rsp_cyc - start_cyc !== TMO) begin
            n_fail++; $display("FAIL watchdog_time: %0d cycles ok=%0d, required %0d", rsp_cyc - start_cyc, ok, TMO);
        end
        wait_idle(ok);
        s0 = start_cnt; r0 = rsp_cnt;
        set_req(2, 1'b0, 7'h12, 8'h34);
        exp_q.push_back({4'b0100, 1'b0, 1'b0, 1'b0, 8'h00});
        wait_rsp(r0 + 1, ok);
        req[2] = 1'b0;
        n_cmp++;
        if (!ok || start_cnt - s0 !== 1 || st_addr !== 7'h12) begin
            n_fail++; $display("FAIL after_watchdog: starts=%0d addr=%h ok=%0d, required 1/12/1", start_cnt - s0, st_addr, ok);
        end
    endtask

    task automatic test_drop_and_change();
        bit ok;
        int s0, r0, g0;
        wait_idle(ok);
        s0 = start_cnt; r0 = rsp_cnt; g0 = gnt_cnt;
        set_req(1, 1'b0, 7'h2A, 8'h3C);
        exp_q.push_back({4'b0010, 1'b0, 1'b0, 1'b0, 8'h00});
        wait_gnt(g0 + 1, ok);
        req[1] = 1'b0;
        req_addr[7 +: 7] = 7'h7F;
        req_wdata[8 +: 8] = 8'h00;
        wait_start(s0 + 1, ok);
        n_cmp++;
        if (!ok || st_addr !== 7'h2A || st_data !== 8'h3C) begin
            n_fail++; $display("FAIL latched_fields: addr/data %h/%h ok=%0d, required 2a/3c", st_addr, st_data, ok);
        end
        wait_rsp(r0 + 1, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL dropped_req_rsp: no rsp_valid within bound, required one"); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int s0, r0, g0;
        wait_idle(ok);
        s0 = start_cnt;
        mdl_lat = 30;
        // this transaction is aborted by reset, so no response is expected for it
        set_req(0, 1'b1, 7'h11, 8'h00);
        wait_start(s0 + 1, ok);
        repeat (5) tick();
        n_cmp++;
        if (!ok || arb_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_wait_busy: arb_busy=%b ok=%0d, required 1", arb_busy, ok);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, arb_busy, m_start, m_rw_bit,
             m_slave_addr, m_tx_data} !== 36'h0) begin
            n_fail++;
            $display("FAIL async_reset: outputs %h, required all 0",
                     {gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, arb_busy, m_start,
                      m_rw_bit, m_slave_addr, m_tx_data});
        end
        req[0] = 1'b0;
        mdl_lat = 4;
        exp_q.delete();
        set_req(3, 1'b0, 7'h33, 8'h44);
        exp_q.push_back({4'b1000, 1'b0, 1'b0, 1'b0, 8'h00});
        repeat (2) tick();
        g0 = gnt_cnt; r0 = rsp_cnt;
        rst_n = 1'b1;
        wait_gnt(g0 + 1, ok);
        n_cmp++;
        if (!ok || gnt_val !== 4'b1000) begin
            n_fail++; $display("FAIL post_reset_gnt: gnt=%b ok=%0d, required 1000", gnt_val, ok);
        end
        wait_rsp(r0 + 1, ok);
        req[3] = 1'b0;
        n_cmp++;
        if (!ok || st_addr !== 7'h33) begin
            n_fail++; $display("FAIL post_reset_rsp: addr=%h ok=%0d, required 33 and a response", st_addr, ok);
        end
    endtask

    initial begin
        bit ok;
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_nack(1'b0);
        test_nack(1'b1);
        test_watchdog();
        test_drop_and_change();
        test_reset_mid_wait();
        wait_idle(ok);
        n_cmp++;
        if (!ok || exp_q.size() != 0) begin
            n_fail++; $display("FAIL final_drain: %0d responses outstanding ok=%0d, required 0", exp_q.size(), ok);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Round-robin arbiter and transaction sequencer that shares one `i2c_master` instance among `N_REQ` on-chip requesters (e.g. LED, FND and switch-poll agents). It sits between the requesters and the master's `start`/`rw_bit`/`slave_addr`/`tx_data` inputs. It issues exactly one single-byte transaction per grant and retries on NACK. It enforces a bus-free gap between transactions and a watchdog timeout, then returns the read data and status to the owning requester.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `MAX_RETRY`, 2: re-issues after a NACK before reporting an error, 0..7.
- `GAP_CYC`, 500: idle clk cycles between the end of a transaction and the next `m_start` (5 us at 100 MHz), ≥1.
- `TIMEOUT_CYC`, 200000: maximum clk cycles from `m_start` to `m_done` (2 ms), ≥16.
- `clk` in 1: 100 MHz system clock. One clock domain only.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester level request. Held until that requester's `rsp_valid`.
- `req_rw` in N_REQ: 1 = read, 0 = write.
- `req_addr` in 7*N_REQ: 7-bit slave address. Slice i is `[7i+6:7i]`.
- `req_wdata` in 8*N_REQ: write byte. Slice i is `[8i+7:8i]`.
- `gnt` out N_REQ: one-hot, owner of the current transaction.
- `rsp_valid` out N_REQ: one-cycle completion pulse to the owner.
- `rsp_rdata` out 8: read byte. Valid with `rsp_valid`, held until the next response.
- `rsp_err` out 1: final NACK or timeout. Valid with `rsp_valid`.
- `rsp_timeout` out 1: error cause was the watchdog. Valid with `rsp_valid`.
- `arb_busy` out 1: state ≠ IDLE.
- `m_start` out 1: one-cycle start pulse to `i2c_master`.
- `m_rw_bit` out 1: to the master.
- `m_slave_addr` out 7: to the master.
- `m_tx_data` out 8: to the master.
- `m_rx_data` in 8: from the master.
- `m_busy` in 1: from the master.
- `m_done` in 1: from the master. One-cycle pulse.
- `m_ack_error` in 1: from the master. Valid with `m_done`.

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.** All outputs reset to 0. `last` (the last-granted index) resets to `N_REQ-1`, so requester 0 wins first. `retry_cnt`, `gap_cnt` and `wd_cnt` reset to 0.
- **IDLE.**
  - If `req` ≠ 0, pick the first set bit searching upward from `last+1`, wrapping at `N_REQ`.
  - Latch that requester's rw/addr/wdata into `m_*`, set `gnt` one-hot, update `last`, clear `retry_cnt`, then go to ISSUE.
- **ISSUE.**
  - If `m_busy` = 1, stay.
  - Otherwise pulse `m_start` for one cycle, clear `wd_cnt`, then go to WAIT.
- **WAIT.**
  - `wd_cnt` increments every cycle.
  - On `m_done` with `m_ack_error` = 0: capture `m_rx_data`, then go to RESP with err = 0.
  - On `m_done` with `m_ack_error` = 1:
    - If `retry_cnt` < `MAX_RETRY`: increment `retry_cnt`, then go to RETRY_GAP.
    - Otherwise go to RESP with err = 1 and timeout = 0.
  - If `wd_cnt` = `TIMEOUT_CYC-1` with no `m_done`: go to RESP with err = 1 and timeout = 1.
  - If `m_done` and the timeout occur in the same cycle, `m_done` wins.
- **RETRY_GAP.** Count `GAP_CYC` cycles, then go to ISSUE. `m_*` fields are unchanged.
- **RESP.** Pulse `rsp_valid[owner]` and drive `rsp_err`/`rsp_timeout` for one cycle. Then go to POST_GAP.
- **POST_GAP.** Count `GAP_CYC` cycles, clear `gnt`, then go to IDLE.
- **Request dropped mid-transaction.** If `req[owner]` drops after the grant, the transaction still completes and `rsp_valid` still pulses.
- **Request field changes.** Changes on `req_*` after the grant are ignored.
- **Fairness.** Requests from non-owners wait. No requester is granted twice in a row while another request is pending.
- **Async reset mid-transaction.** The block returns to IDLE immediately with outputs at 0. The master is reset by the same `rst_n`.

## Timing
- **Request to start.** `req` sampled high in IDLE at edge k gives `gnt` and `m_*` valid after k, and `m_start` high in the cycle after k+1 (2-cycle request-to-start latency, `m_busy` = 0).
- **`m_start` width.** Exactly one cycle per issue. Never asserted while `m_busy` = 1.
- **Done to response.** `m_done` sampled at edge d puts `rsp_valid` high during cycle d+1, when the result is not a retry.
- **Retry spacing.** Start-to-start spacing for a retry is ≥ `GAP_CYC`+2 cycles after `m_done`.
- **Back-to-back grants.** Spacing between consecutive grants is ≥ `GAP_CYC`+1 cycles after `rsp_valid`.
- **`gnt` hold.** `gnt` stays stable from grant through the end of POST_GAP.

## Test plan
- **Single write.** `req[1]` with rw = 0, addr = 0x55, wdata = 0xFF; master model ACKs.
  - One `m_start` with `m_slave_addr` = 0x55 and `m_tx_data` = 0xFF.
  - `rsp_valid[1]` pulses one cycle after `m_done`, with `rsp_err` = 0.
- **Read.** `req[2]` with rw = 1, addr = 0x57; model returns 0xA5.
  - `rsp_rdata` = 0xA5 and `rsp_valid[2]` = 1.
  - `rsp_rdata` holds 0xA5 after the pulse.
- **Round robin.** All four `req` high continuously.
  - Grants go 0, 1, 2, 3, 0.
  - Each pair of grants is separated by ≥ `GAP_CYC`+1 cycles.
- **NACK retry.**
  - Model NACKs twice then ACKs (`MAX_RETRY` = 2): 3 `m_start` pulses, `rsp_err` = 0.
  - Model NACKs always: 3 pulses, then `rsp_err` = 1 and `rsp_timeout` = 0.
- **Watchdog.** Model never asserts `m_done` (`TIMEOUT_CYC` = 64).
  - `rsp_valid` with `rsp_err` = 1 and `rsp_timeout` = 1 exactly 64 cycles after `m_start`.
  - Next grant proceeds normally.
- **Reset mid-WAIT.**
  - `rst_n` low in WAIT: all outputs are 0 asynchronously.
  - After release with `req[3]` high, `req[0]`… are not pending, so `req[3]` is granted and completes.
